// File: rtl/seq_engine.sv
// Sequence engine for the quadrant memory game: grows an LFSR-driven quadrant
// sequence, paces its display for the VGA overlay and checks player selections.
//
// fetch phase | meaning
// PH_IDLE     | not fetching, or first fetch cycle (append decided here)
// PH_APPENDED | element just written, len updated
// PH_SETTLE   | settle cycle, randReady still low
// PH_READY    | randReady/done valid and held
module seq_engine #(
    parameter int          MAX_LEN     = 8,
    parameter int          DISP_CYCLES = 25000000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] step,
    input  logic       select,
    output logic       randReady,
    output logic       done,
    output logic       win,
    output logic       finish,
    output logic       hl_valid,
    output logic [1:0] hl_quad,
    output logic [3:0] seq_len
);

    localparam int              TW         = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(DISP_CYCLES - 1);
    localparam logic [3:0]      LEN_MAX    = 4'(MAX_LEN);
    localparam logic [3:0]      ST_IDLE    = 4'd0;
    localparam logic [3:0]      ST_FETCH   = 4'd1;
    localparam logic [3:0]      ST_SHOW    = 4'd2;

    typedef enum logic [1:0] {PH_IDLE, PH_APPENDED, PH_SETTLE, PH_READY} phase_t;

    phase_t          phase, phase_nxt;
    logic [15:0]     lfsr;
    logic [1:0]      mem [MAX_LEN];
    logic [3:0]      len, show_idx, chk_idx, chk_next;
    logic            need_append;
    logic [TW-1:0]   timer;
    logic            sel_prev;
    logic [1:0]      last_guess, guess, mem_show, mem_chk;
    logic            do_append, timer_tc, in_cursor, sel_event, lfsr_fb;

    always_comb begin
        phase_nxt = PH_IDLE;
        do_append = 1'b0;
        if (step == ST_FETCH) begin
            case (phase)
                PH_IDLE: begin
                    if (need_append && (len < LEN_MAX)) begin
                        do_append = 1'b1;
                        phase_nxt = PH_APPENDED;
                    end else begin
                        phase_nxt = PH_SETTLE;
                    end
                end
                PH_APPENDED: phase_nxt = PH_SETTLE;
                PH_SETTLE:   phase_nxt = PH_READY;
                PH_READY:    phase_nxt = PH_READY;
                default:     phase_nxt = PH_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_show = 2'd0;
        mem_chk  = 2'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (show_idx == 4'(i)) mem_show = mem[i];
            if (chk_idx == 4'(i))  mem_chk  = mem[i];
        end
    end

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign timer_tc  = (step == ST_SHOW) && (timer == TIMER_LAST);
    assign in_cursor = (step >= 4'd3) && (step <= 4'd6);
    // Once win or finish is set the game is frozen until a new game starts.
    assign sel_event = in_cursor && select && !sel_prev && !win && !finish;
    assign guess     = 2'(step - 4'd3);
    assign chk_next  = chk_idx + 4'd1;
    assign hl_quad   = (show_idx < len) ? mem_show : last_guess;
    assign seq_len   = len;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PH_IDLE;
            lfsr        <= LFSR_SEED;
            len         <= 4'd0;
            show_idx    <= 4'd0;
            chk_idx     <= 4'd0;
            need_append <= 1'b1;
            timer       <= '0;
            sel_prev    <= 1'b0;
            last_guess  <= 2'd0;
            randReady   <= 1'b0;
            done        <= 1'b0;
            win         <= 1'b0;
            finish      <= 1'b0;
            hl_valid    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) mem[i] <= 2'd0;
        end else begin
            phase     <= phase_nxt;
            lfsr      <= {lfsr[14:0], lfsr_fb};
            sel_prev  <= select;
            randReady <= 1'b0;
            done      <= 1'b0;
            hl_valid  <= 1'b0;
            timer     <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (do_append && (len == 4'(i))) mem[i] <= lfsr[1:0];
            end
            case (step)
                ST_IDLE: begin
                    len         <= 4'd0;
                    show_idx    <= 4'd0;
                    chk_idx     <= 4'd0;
                    win         <= 1'b0;
                    finish      <= 1'b0;
                    need_append <= 1'b1;
                end
                ST_FETCH: begin
                    if (do_append) begin
                        len         <= len + 4'd1;
                        need_append <= 1'b0;
                        show_idx    <= 4'd0;
                    end
                    randReady <= (phase_nxt == PH_READY);
                    done      <= (phase_nxt == PH_READY) && (show_idx == len);
                end
                ST_SHOW: begin
                    hl_valid <= 1'b1;
                    if (timer_tc) begin
                        done <= 1'b1;
                        if (show_idx < len) show_idx <= show_idx + 4'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    if (sel_event) begin
                        last_guess <= guess;
                        if (guess != mem_chk) begin
                            finish <= 1'b1;
                        end else if (chk_next < len) begin
                            chk_idx <= chk_next;
                        end else if (len == LEN_MAX) begin
                            win <= 1'b1;
                        end else begin
                            need_append <= 1'b1;
                            chk_idx     <= 4'd0;
                            show_idx    <= 4'd0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_engine.sv
// Bench for seq_engine (MAX_LEN=3, DISP_CYCLES=4): scoreboard of appended
// quadrants, popped and compared as each element is highlighted.
module tb_seq_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] step;
    logic       select;
    logic       randReady, done, win, finish, hl_valid;
    logic [1:0] hl_quad;
    logic [3:0] seq_len;

    int checks = 0;
    int passed = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  seq_model [3];
    logic [1:0]  sb_q [$];

    always #5 clk = ~clk;

    seq_engine #(.MAX_LEN(3), .DISP_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .step(step), .select(select),
        .randReady(randReady), .done(done), .win(win), .finish(finish),
        .hl_valid(hl_valid), .hl_quad(hl_quad), .seq_len(seq_len)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, reseeded by rst, free-running otherwise.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; step = 4'd0; select = 1'b0;
        repeat (3) tick();
        checks++;
        if ({randReady, done, win, finish, hl_valid, hl_quad, seq_len} !== 11'd0)
            $display("FAIL reset_outputs: got %b want 0", {randReady, done, win, finish, hl_valid, hl_quad, seq_len});
        else passed++;
        checks++;
        if (dut.lfsr !== 16'hACE1) $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr);
        else passed++;
        checks++;
        if (dut.need_append !== 1'b1) $display("FAIL reset_need_append: got %b want 1", dut.need_append);
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch_append();
        logic [1:0] e;
        step = 4'd1;
        e = m_lfsr[1:0];
        seq_model[0] = e;
        sb_q.push_back(e);
        tick();
        checks++;
        if (seq_len !== 4'd1) $display("FAIL fetch_len_c1: got %0d want 1", seq_len);
        else passed++;
        checks++;
        if (randReady !== 1'b0) $display("FAIL fetch_rr_c1: got %b want 0", randReady);
        else passed++;
        tick();
        checks++;
        if (randReady !== 1'b0) $display("FAIL fetch_rr_c2: got %b want 0", randReady);
        else passed++;
        tick();
        checks++;
        if (randReady !== 1'b1) $display("FAIL fetch_rr_c3: got %b want 1", randReady);
        else passed++;
        checks++;
        if (done !== 1'b0) $display("FAIL fetch_done_c3: got %b want 0", done);
        else passed++;
    endtask

    task automatic test_show_timer();
        logic [1:0] e;
        e = sb_q.pop_front();
        step = 4'd2;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (hl_valid !== 1'b1) $display("FAIL show_hl_valid c%0d: got %b want 1", c, hl_valid);
            else passed++;
            checks++;
            if (done !== (c == 4)) $display("FAIL show_done c%0d: got %b want %b", c, done, (c == 4));
            else passed++;
            if (c <= 3) begin
                checks++;
                if (hl_quad !== e) $display("FAIL show_hl_quad c%0d: got %0d want %0d", c, hl_quad, e);
                else passed++;
            end
        end
        step = 4'd1;
        tick();
        checks++;
        if (hl_valid !== 1'b0) $display("FAIL show_exit_hl_valid: got %b want 0", hl_valid);
        else passed++;
        checks++;
        if (randReady !== 1'b0) $display("FAIL refetch_rr_c1: got %b want 0", randReady);
        else passed++;
        tick();
        checks++;
        if ({randReady, done} !== 2'b11) $display("FAIL refetch_rr_done_c2: got %b want 11", {randReady, done});
        else passed++;
        checks++;
        if (seq_len !== 4'd1) $display("FAIL refetch_no_append: got %0d want 1", seq_len);
        else passed++;
    endtask

    task automatic test_correct_guess();
        logic [1:0] e;
        int pulses;
        step = 4'd3 + {2'b00, seq_model[0]};
        select = 1'b1;
        repeat (3) tick();
        select = 1'b0;
        tick();
        checks++;
        if ({win, finish} !== 2'b00) $display("FAIL guess1_win_finish: got %b want 00", {win, finish});
        else passed++;
        checks++;
        if (dut.chk_idx !== 4'd0) $display("FAIL guess1_chk_idx: got %0d want 0", dut.chk_idx);
        else passed++;
        checks++;
        if (dut.need_append !== 1'b1) $display("FAIL guess1_need_append: got %b want 1", dut.need_append);
        else passed++;
        step = 4'd1;
        e = m_lfsr[1:0];
        seq_model[1] = e;
        sb_q.push_back(e);
        repeat (3) tick();
        checks++;
        if (seq_len !== 4'd2) $display("FAIL fetch2_len: got %0d want 2", seq_len);
        else passed++;
        checks++;
        if ({randReady, done} !== 2'b10) $display("FAIL fetch2_rr_done: got %b want 10", {randReady, done});
        else passed++;
        step = 4'd2;
        pulses = 0;
        sb_q.push_front(seq_model[0]);
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (done) pulses++;
            if (c == 1 || c == 5) begin
                e = sb_q.pop_front();
                checks++;
                if (hl_quad !== e) $display("FAIL show2_hl_quad c%0d: got %0d want %0d", c, hl_quad, e);
                else passed++;
            end
        end
        checks++;
        if (hl_quad !== seq_model[0]) $display("FAIL show2_last_guess: got %0d want %0d", hl_quad, seq_model[0]);
        else passed++;
        checks++;
        if (pulses != 2) $display("FAIL show2_pulses: got %0d want 2", pulses);
        else passed++;
        step = 4'd1;
        repeat (2) tick();
    endtask

    task automatic test_wrong_guess();
        logic [1:0] wq;
        wq = seq_model[0] + 2'd1;
        step = 4'd3 + {2'b00, wq};
        select = 1'b1;
        repeat (2) tick();
        select = 1'b0;
        tick();
        checks++;
        if ({win, finish} !== 2'b01) $display("FAIL wrong_finish: got win/finish %b want 01", {win, finish});
        else passed++;
        step = 4'd3 + {2'b00, seq_model[0]};
        select = 1'b1;
        tick();
        select = 1'b0;
        tick();
        checks++;
        if ({win, finish} !== 2'b01) $display("FAIL wrong_finish_held: got win/finish %b want 01", {win, finish});
        else passed++;
        step = 4'd0;
        tick();
        checks++;
        if ({finish, seq_len} !== 5'd0) $display("FAIL new_game_clear: got %b want 0", {finish, seq_len});
        else passed++;
    endtask

    task automatic test_full_win();
        logic [1:0] e, wq;
        int pulses;
        for (int r = 1; r <= 3; r++) begin
            step = 4'd1;
            e = m_lfsr[1:0];
            seq_model[r-1] = e;
            for (int k = 0; k < r - 1; k++) sb_q.push_back(seq_model[k]);
            sb_q.push_back(e);
            repeat (3) tick();
            checks++;
            if (seq_len !== 4'(r)) $display("FAIL win_r%0d_len: got %0d want %0d", r, seq_len, r);
            else passed++;
            checks++;
            if ({randReady, done} !== 2'b10) $display("FAIL win_r%0d_fetch: got %b want 10", r, {randReady, done});
            else passed++;
            step = 4'd2;
            pulses = 0;
            for (int c = 1; c <= 4 * r + 1; c++) begin
                tick();
                if (done) pulses++;
                if ((c - 1) % 4 == 0 && c <= 4 * r) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (hl_quad !== e) $display("FAIL win_r%0d_hl_quad c%0d: got %0d want %0d", r, c, hl_quad, e);
                    else passed++;
                end
                if (c == 4 * r + 1 && r >= 2) begin
                    checks++;
                    if (hl_quad !== seq_model[r-2])
                        $display("FAIL win_r%0d_last_guess: got %0d want %0d", r, hl_quad, seq_model[r-2]);
                    else passed++;
                end
            end
            checks++;
            if (pulses != r) $display("FAIL win_r%0d_pulses: got %0d want %0d", r, pulses, r);
            else passed++;
            step = 4'd1;
            repeat (2) tick();
            checks++;
            if ({randReady, done} !== 2'b11) $display("FAIL win_r%0d_all_shown: got %b want 11", r, {randReady, done});
            else passed++;
            for (int i = 0; i < r; i++) begin
                step = 4'd3 + {2'b00, seq_model[i]};
                select = 1'b1;
                repeat (2) tick();
                select = 1'b0;
                tick();
            end
            checks++;
            if ({win, finish} !== ((r == 3) ? 2'b10 : 2'b00))
                $display("FAIL win_r%0d_result: got win/finish %b want %b", r, {win, finish}, (r == 3) ? 2'b10 : 2'b00);
            else passed++;
        end
        checks++;
        if (seq_len !== 4'd3) $display("FAIL win_len: got %0d want 3", seq_len);
        else passed++;
        wq = seq_model[0] + 2'd1;
        step = 4'd3 + {2'b00, wq};
        select = 1'b1;
        tick();
        select = 1'b0;
        tick();
        checks++;
        if ({win, finish} !== 2'b10) $display("FAIL win_held: got win/finish %b want 10", {win, finish});
        else passed++;
    endtask

    task automatic test_reset_mid_show();
        step = 4'd2;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({randReady, done, win, finish, hl_valid, hl_quad, seq_len} !== 11'd0)
            $display("FAIL midrst_outputs: got %b want 0", {randReady, done, win, finish, hl_valid, hl_quad, seq_len});
        else passed++;
        checks++;
        if (dut.lfsr !== 16'hACE1) $display("FAIL midrst_lfsr: got %h want ace1", dut.lfsr);
        else passed++;
        rst = 1'b0;
        step = 4'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_append();
        test_show_timer();
        test_correct_guess();
        test_wrong_guess();
        test_full_win();
        test_reset_mid_show();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
